// File: rtl/artyz7_led_sequencer.sv
// artyz7_led_sequencer
// Steps an LED pattern (binary count or rotate-left) once every TICK_CYCLES
// enabled clocks, accepts pattern loads through a valid/ready handshake and
// dims the LEDs with a free-running PWM.
// Optional feature macro: ARTYZ7_LED_SEQUENCER_PWM_EN
//   defined   -> PWM counter and brightness dimming are built
//   undefined -> brightness is ignored, LEDs show the pattern at full duty
module artyz7_led_sequencer #(
  parameter int NUM_LEDS    = 4,
  parameter int TICK_CYCLES = 125000000,
  parameter int PWM_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [PWM_WIDTH-1:0] brightness,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [NUM_LEDS-1:0]  load_pattern,
  output logic [NUM_LEDS-1:0]  leds,
  output logic                 tick
);

  localparam int               CNT_W    = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0]    r_tick_cnt;
  logic [NUM_LEDS-1:0] r_pattern;
  logic                r_out_of_reset;
  logic                r_tick;
  logic [NUM_LEDS-1:0] r_leds;

  logic                w_step;
  logic                w_load;
  logic                w_pwm_on;
  logic [NUM_LEDS-1:0] w_next_pattern;

  assign w_step     = enable && (r_tick_cnt == CNT_LAST);
  assign load_ready = r_out_of_reset && !w_step;
  assign w_load     = load_valid && load_ready;

  // Next pattern for a step: increment (wraps naturally) or rotate left
  always_comb begin
    w_next_pattern = r_pattern + NUM_LEDS'(1);
    if (mode) begin
      w_next_pattern = (r_pattern << 1) | (r_pattern >> (NUM_LEDS - 1));
    end
  end

  // Ready qualifier: low only while reset is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_out_of_reset <= 1'b0;
    else          r_out_of_reset <= 1'b1;
  end

  // Tick counter and pattern; a step cycle blocks loads, so the load
  // lands one cycle later on top of the already-stepped pattern
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
      r_pattern  <= NUM_LEDS'(1);
    end else if (w_load) begin
      r_tick_cnt <= '0;
      r_pattern  <= load_pattern;
    end else if (w_step) begin
      r_tick_cnt <= '0;
      r_pattern  <= w_next_pattern;
    end else if (enable) begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  // Tick pulse in the cycle following each step cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tick <= 1'b0;
    else          r_tick <= w_step;
  end

`ifdef ARTYZ7_LED_SEQUENCER_PWM_EN
  logic [PWM_WIDTH-1:0] r_pwm_cnt;

  // Free-running PWM counter, independent of enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pwm_cnt <= '0;
    else          r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
  end

  assign w_pwm_on = (r_pwm_cnt < brightness);
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;
  assign w_pwm_on            = 1'b1;
`endif

  // Registered LED drive, blanked while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_leds <= '0;
    else if (enable)  r_leds <= r_pattern & {NUM_LEDS{w_pwm_on}};
    else              r_leds <= '0;
  end

  assign leds = r_leds;
  assign tick = r_tick;

endmodule

// File: tb/tb_artyz7_led_sequencer.sv
// tb_artyz7_led_sequencer
// Directed scenarios followed by a randomized run, every cycle compared
// against a behavioural model of the sequencer. Honours the
// ARTYZ7_LED_SEQUENCER_PWM_EN macro the same way the design does.
module tb_artyz7_led_sequencer;

  localparam int NL = 4;
  localparam int TC = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          mode;
  logic [PW-1:0] brightness;
  logic          load_valid;
  logic          load_ready;
  logic [NL-1:0] load_pattern;
  logic [NL-1:0] leds;
  logic          tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_pat, m_cnt, m_pwm, m_leds, m_tick, m_rdy;

  artyz7_led_sequencer #(
    .NUM_LEDS   (NL),
    .TICK_CYCLES(TC),
    .PWM_WIDTH  (PW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mode        (mode),
    .brightness  (brightness),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_pattern(load_pattern),
    .leds        (leds),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = 1; m_cnt = 0; m_pwm = 0; m_leds = 0; m_tick = 0; m_rdy = 0;
  endtask

  function automatic int pwm_on_now();
`ifdef ARTYZ7_LED_SEQUENCER_PWM_EN
    return (m_pwm < int'(brightness)) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  // One clock: check ready mid-cycle, advance model at the edge, check outputs after it
  task automatic step();
    bit stp;
    bit acc;
    stp = (enable === 1'b1) && (m_cnt == TC - 1);
    @(negedge clk);
    chk("load_ready", {31'd0, load_ready}, ((m_rdy != 0) && !stp) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (reset_n) begin
      acc    = load_valid && (m_rdy != 0) && !stp;
      m_leds = enable ? (pwm_on_now() != 0 ? m_pat : 0) : 0;
      m_tick = stp ? 1 : 0;
      if (acc) begin
        m_pat = int'(load_pattern);
        m_cnt = 0;
      end else if (stp) begin
        if (mode) m_pat = ((m_pat * 2) % 16) + (m_pat / 8);
        else      m_pat = (m_pat + 1) % 16;
        m_cnt = 0;
      end else if (enable) begin
        m_cnt = m_cnt + 1;
      end
      m_pwm = (m_pwm + 1) % (1 << PW);
      m_rdy = 1;
    end
    #1;
    chk("leds", {28'd0, leds}, m_leds);
    chk("tick", {31'd0, tick}, m_tick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse starting mid-period
  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_leds", {28'd0, leds}, 0);
    chk("rst_ready", {31'd0, load_ready}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    model_reset();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int guard;
    reset_n = 1'b0; enable = 1'b0; mode = 1'b0; brightness = '0;
    load_valid = 1'b0; load_pattern = '0;
    model_reset();
    run(3);
    chk("reset_leds", {28'd0, leds}, 0);
    chk("reset_ready", {31'd0, load_ready}, 0);
    reset_n = 1'b1;

    // Binary count at near-full brightness through a full wrap
    enable = 1'b1; brightness = 2'd3;
    run(TC * 17 + 2);

    // Rotate from 1000, then an all-zero pattern stays zero
    mode = 1'b1; load_pattern = 4'b1000; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    run(TC * 2 + 1);
    load_pattern = 4'b0000; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    run(TC * 8 + 1);

    // Load held across a step cycle: refused there, accepted next cycle
    mode = 1'b0; load_pattern = 4'b0011; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    guard = 0;
    while (m_cnt != TC - 1 && guard < 2 * TC) begin
      step();
      guard++;
    end
    chk("reach_step_cycle", m_cnt, TC - 1);
    load_pattern = 4'b1010; load_valid = 1'b1;
    step();
    step();
    load_valid = 1'b0;
    chk("post_load_count", m_cnt, 0);
    run(TC + 2);

    // Freeze mid-count, then resume
    run(2);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(TC * 2);

    // Zero brightness, then a reset mid-period
    brightness = 2'd0;
    run(TC * 3);
    reset_pulse();
    run(TC * 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 7) == 0)  brightness = PW'($urandom_range(0, 3));
      load_valid   = ($urandom_range(0, 5) == 0);
      load_pattern = NL'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) reset_pulse();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/artyz7_led_sequencer.md
ARTYZ7_LED_SEQUENCER -- requirements
Module: artyz7_led_sequencer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, the number of board LEDs driven (top level sets it from the board package).
REQ-002 SHALL have parameter TICK_CYCLES, default 125000000, clk cycles per pattern step (1 s at 125 MHz); legal range >= 2.
REQ-003 SHALL have parameter PWM_WIDTH, default 8, the brightness and PWM counter width.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all registers on rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1 bit: 1 runs the sequencer, 0 freezes it.
REQ-007 SHALL have port mode, input, 1 bit: 0 selects binary count, 1 selects rotate-left.
REQ-008 SHALL have port brightness, input, PWM_WIDTH bits: LED on-duty numerator.
REQ-009 SHALL have port load_valid, input, 1 bit: load_pattern is valid.
REQ-010 SHALL have port load_ready, output, 1 bit: block accepts a load this cycle.
REQ-011 SHALL have port load_pattern, input, NUM_LEDS bits: new pattern value.
REQ-012 SHALL have port leds, output, NUM_LEDS bits: registered LED drive, to top-level pins.
REQ-013 SHALL have port tick, output, 1 bit: one-cycle pulse after each pattern step.

Function
REQ-014 Tick counter SHALL count 0..TICK_CYCLES-1 while enable=1, wrap to 0, and hold while enable=0.
REQ-015 A step cycle SHALL be any cycle with enable=1 and tick counter = TICK_CYCLES-1.
REQ-016 At the edge ending a step cycle, pattern SHALL become pattern+1 mod 2^NUM_LEDS (mode=0) or pattern rotated left by one, MSB into LSB (mode=1).
REQ-017 tick SHALL be 1 in exactly the cycle after each step cycle, 0 otherwise.
REQ-018 load_ready SHALL be 0 in step cycles and 1 in all other cycles out of reset; it may depend combinationally on enable.
REQ-019 On load_valid=1 and load_ready=1 at an edge, pattern SHALL take load_pattern and tick counter SHALL reset to 0.
REQ-020 load_valid held across a step cycle SHALL be accepted in the next cycle, using the then-current pattern as overwrite target (step first, load second).
REQ-021 Rotate of an all-zero pattern SHALL stay all-zero; count SHALL wrap all-ones to zero.
REQ-022 PWM counter SHALL free-run 0..2^PWM_WIDTH-1 and wrap, regardless of enable.
REQ-023 pwm_on SHALL be (PWM counter < brightness): brightness 0 gives always off, all-ones gives on 2^PWM_WIDTH-1 of 2^PWM_WIDTH cycles.
REQ-024 leds SHALL register (pattern AND pwm_on) when enable=1, and all-zero when enable=0, one cycle of latency.
REQ-025 mode and brightness changes SHALL take effect from the next step / next cycle respectively, with no reset of counters.

Reset
REQ-026 While reset_n=0: tick counter 0, PWM counter 0, pattern 1 (LSB set), leds 0, tick 0, load_ready 0.
REQ-027 Reset assertion mid-step or mid-load SHALL discard that operation; first step after release occurs TICK_CYCLES enabled cycles later.

Configuration
REQ-028 Macro ARTYZ7_LED_SEQUENCER_PWM_EN defined: PWM counter and brightness dimming SHALL be implemented per REQ-022..REQ-024.
REQ-029 Macro undefined: no PWM counter, brightness SHALL be ignored, pwm_on SHALL be constant 1 (leds = pattern when enabled).

Verification (TICK_CYCLES=4, PWM_WIDTH=2, NUM_LEDS=4, macro defined unless stated)
REQ-030 Reset release, enable=1, mode=0, brightness=3 -> tick every 4th cycle; pattern 1,2,3,...,15,0; leds show pattern in 3 of every 4 cycles.
REQ-031 mode=1 from pattern 4'b1000 -> after one step pattern 4'b0001; load 4'b0000 -> stays 0 for 8 steps.
REQ-032 load_valid=1 with 4'b1010 during a step cycle -> load_ready=0 that cycle, pattern steps, load accepted next cycle, pattern 4'b1010, next tick 4 cycles later.
REQ-033 enable=0 for 10 cycles mid-count -> leds 0, no tick, pattern and tick counter unchanged; on re-enable, step resumes from held count.
REQ-034 brightness=0 -> leds all-zero always; reset_n pulsed low mid-period -> leds 0, load_ready 0 immediately, pattern 1 after release.
REQ-035 Macro undefined, brightness=0 -> leds equal pattern every enabled cycle.
